// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, fixed WIDTH+1 cycle latency
// Define SIGNED_MULT_EN for two's complement operands and product.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic               add_enable
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [CNT_W-1:0]   r_cnt;

`ifdef SIGNED_MULT_EN
  logic r_neg;

  // Magnitudes are taken as unsigned, so -2^(WIDTH-1) negates to 2^(WIDTH-1).
  assign w_a_mag  = a[WIDTH-1] ? -a : a;
  assign w_b_mag  = b[WIDTH-1] ? -b : b;
  assign w_result = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign w_a_mag  = a;
  assign w_b_mag  = b;
  assign w_result = r_acc;
`endif

  assign ready = (r_state == S_IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CALC;
      S_CALC:  if (r_cnt == CNT_LAST) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      PRODUCT    <= '0;
      add_enable <= 1'b0;
    end else begin
      add_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplr  <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          if (r_mplr[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          PRODUCT    <= w_result;
          add_enable <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier against an arithmetic reference
module tb_seq_multiplier;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           ready;
  logic           busy;
  logic [2*W-1:0] PRODUCT;
  logic           add_enable;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .busy       (busy),
    .PRODUCT    (PRODUCT),
    .add_enable (add_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             c;
  } exp_t;

  exp_t           q[$];
  int             cyc = 0;
  int             next_accept = 0;
  logic [2*W-1:0] model_product = '0;
  bit             check_en = 1'b0;
  int             n_cmp = 0;
  int             n_bad = 0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint px;
    longint py;
`ifdef SIGNED_MULT_EN
    px = longint'($signed(x));
    py = longint'($signed(y));
`else
    px = longint'({48'd0, x});
    py = longint'({48'd0, y});
`endif
    return (2*W)'(px * py);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (check_en) begin
      if (add_enable === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_add_enable", 64'(add_enable), 64'd0);
        end else begin
          chk("pulse_cycle", 64'(cyc), 64'(q[0].c));
          chk("product_on_pulse", 64'(PRODUCT), 64'(q[0].p));
          model_product = q[0].p;
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].c) begin
        chk("missing_add_enable", 64'(add_enable), 64'd1);
        model_product = q[0].p;
        void'(q.pop_front());
      end
      chk("product_hold", 64'(PRODUCT), 64'(model_product));
      chk("ready", 64'(ready), 64'(cyc >= next_accept - 1));
      chk("busy", 64'(busy), 64'(cyc < next_accept - 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, output bit acc, output int e);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    e = cyc + 1;
    acc = (e >= next_accept);
    if (acc) begin
      q.push_back('{ref_mul(x, y), e + W + 1});
      next_accept = e + W + 2;
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic do_reset();
    int r;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    r = cyc + 1;
    q.delete();
    model_product = '0;
    next_accept = r + 1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    int e0;
    int e;
    int budget;

    repeat (3) @(negedge clk);
    next_accept = cyc + 1;
    model_product = '0;
    reset = 1'b0;
    check_en = 1'b1;
    idle(40);

`ifdef SIGNED_MULT_EN
    issue(16'hFFFD, 16'd5, acc, e);
    idle(20);
    issue(16'h8000, 16'h8000, acc, e);
    idle(20);
    issue(16'h7FFF, 16'h8000, acc, e);
    idle(20);
`endif
    issue(16'd3, 16'd5, acc, e);
    idle(20);
    issue(16'hFFFF, 16'hFFFF, acc, e);
    idle(20);
    issue(16'h0000, 16'h1234, acc, e);
    idle(20);

    // Start ignored while busy, then back-to-back issue on the add_enable edge.
    issue(16'd2, 16'd2, acc, e0);
    idle(3);
    issue(16'd9, 16'd9, acc, e);
    while (cyc < e0 + 16) @(negedge clk);
    issue(16'd9, 16'd9, acc, e);
    idle(20);

    // Reset in the middle of a calculation aborts it.
    issue(16'd7, 16'd7, acc, e0);
    while (cyc < e0 + 6) @(negedge clk);
    do_reset();
    idle(30);
    issue(16'd7, 16'd7, acc, e);
    idle(20);

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 22));
      issue(W'($urandom), W'($urandom), acc, e);
    end

    budget = 0;
    while (q.size() > 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier that feeds the accumulate stage of the MAC datapath. It accepts two WIDTH-bit operands on a start pulse, takes WIDTH compute cycles, and presents a 2·WIDTH-bit `PRODUCT`. In the same cycle it pulses `add_enable`, so the downstream adder registers `PRODUCT + ps` on the following edge. It trades throughput for a single adder's worth of area, so no array multiplier is needed.

## Interface
- `WIDTH`, default 16: operand width. `PRODUCT` is 2·WIDTH bits (32 at the default).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request a multiply. Sampled only while `ready`=1.
- `a`  input  WIDTH  multiplicand. Sampled on the accepting edge only.
- `b`  input  WIDTH  multiplier. Sampled on the accepting edge only.
- `ready`  output  1  high in IDLE. Combinational decode of state.
- `busy`  output  1  high in CALC and DONE. Equal to `~ready`.
- `PRODUCT`  output  2·WIDTH  registered result. Holds its value until the next completion.
- `add_enable`  output  1  registered one-cycle pulse marking a new `PRODUCT`.

## Operation
- States: IDLE, CALC, DONE. Encoding is free.
- Reset (synchronous, priority over all else):
  - state goes to IDLE.
  - `PRODUCT`, `add_enable`, the internal accumulator, shifted operands and iteration counter all go to 0.
  - Reset during CALC or DONE aborts the operation. No `add_enable` pulse follows.
- IDLE, `start`=1:
  - latch `mcand`←a and `mplr`←b (2·WIDTH-bit and WIDTH-bit registers), clear `acc`, set `cnt`←0.
  - go to CALC.
- IDLE, `start`=0: hold.
- CALC, each cycle:
  - if `mplr[0]`, `acc` ← `acc` + `mcand`, modulo 2^(2·WIDTH).
  - `mcand` ← `mcand`<<1; `mplr` ← `mplr`>>1 (logical); `cnt`++.
  - After exactly WIDTH CALC cycles (`cnt`=WIDTH-1 on the last), go to DONE. Early termination is not allowed: latency is fixed.
- DONE, one cycle:
  - `PRODUCT` ← final `acc` (sign-corrected, see Configuration).
  - `add_enable` ← 1.
  - go to IDLE.
- `add_enable` is 0 in every cycle except the one following the DONE→IDLE transition edge.
- `start` while `busy`=1 is ignored and not queued.
- Operand changes after the accepting edge have no effect.
- No overflow is possible: a full WIDTH×WIDTH product always fits in 2·WIDTH bits.

## Timing
- Edge E0: `start`=1 sampled in IDLE. After E0: `ready`=0, `busy`=1.
- Edges E1..E_WIDTH: CALC iterations.
- Edge E_{WIDTH+1}: DONE executes. After it, `PRODUCT` is valid, `add_enable`=1, `ready`=1.
- Start-to-result latency: WIDTH+1 cycles (17 at the default).
- `add_enable` and `PRODUCT` change on the same edge. The downstream adder samples both on E_{WIDTH+2}.
- Back-to-back: a new `start` may be accepted on E_{WIDTH+2}, the edge on which `add_enable` is high.
  - Minimum issue interval: WIDTH+2 cycles.
  - `PRODUCT` is unchanged until that next operation's DONE.

## Configuration
- `SIGNED_MULT_EN` defined: `a`, `b` and `PRODUCT` are two's complement.
  - On accept, latch |a| and |b| as WIDTH-bit unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Record `neg` = a[MSB]^b[MSB].
  - In DONE, `PRODUCT` ← `neg` ? -`acc` : `acc`.
  - Latency is unchanged.
- `SIGNED_MULT_EN` undefined: all values are unsigned and there is no correction logic.

## Test plan
- Reset, then 40 idle cycles: `PRODUCT`=0, `add_enable`=0 throughout, `ready`=1.
- Unsigned, a=3, b=5, start at E0: `PRODUCT`=0x0000000F with `add_enable`=1 in exactly the cycle after E17; `add_enable` is 0 one cycle later.
- Unsigned, a=0xFFFF, b=0xFFFF: `PRODUCT`=0xFFFE0001. Then a=0, b=0x1234: `PRODUCT`=0x00000000, still with an `add_enable` pulse.
- `SIGNED_MULT_EN`:
  - a=0xFFFD (−3), b=5 → 0xFFFFFFF1.
  - a=b=0x8000 → 0x40000000.
  - a=0x7FFF, b=0x8000 → 0xC0008000.
- Start a=2, b=2. Pulse `start` with a=9, b=9 at E5: ignored, `PRODUCT`=4 at E17. Then issue start on E18 with a=9, b=9: accepted, `PRODUCT`=0x51 at E35.
- Start a=7, b=7, assert `reset` at E8: state IDLE and `PRODUCT`=0 after E8, no `add_enable` pulse in the following 30 cycles. A new start then completes normally.
